// File: rtl/npu_pkg.sv
// npu_pkg: constants and types shared by the NPU datapath blocks.
//   INT8_MIN / INT8_MAX  : signed INT8 output range
//   ACC_W_DEF            : default MAC accumulator width
//   MULT_W_DEF           : default requant multiplier width
//   SHIFT_W_DEF          : default requant shift-amount width
//   VAL_W                : width of the product carried in beat_t
//   beat_t               : per-beat record entering the requant round/clamp stage
// Optional feature macro consumed by users of this package: REQUANT_RELU_EN.
package npu_pkg;

  localparam int unsigned ACC_W_DEF   = 32;
  localparam int unsigned MULT_W_DEF  = 16;
  localparam int unsigned SHIFT_W_DEF = 6;

  // Full-precision (acc + bias) * mult never overflows at this width.
  localparam int unsigned VAL_W = ACC_W_DEF + MULT_W_DEF + 1;

  localparam logic signed [7:0] INT8_MIN = 8'sh80;
  localparam logic signed [7:0] INT8_MAX = 8'sh7F;

  typedef struct packed {
    logic signed [VAL_W-1:0]   value;
    logic [SHIFT_W_DEF-1:0]    shift;
    logic signed [7:0]         zp;
    logic                      relu;
  } beat_t;

endpackage

// File: rtl/requant_round_sat.sv
// requant_round_sat: combinational final requant stage.
//   value : signed full-precision product
//   shift : arithmetic right-shift amount (0..47 meaningful)
//   zp    : signed output zero point
//   relu  : raise the lower clamp bound to zp (only driven when REQUANT_RELU_EN is defined)
//   data  : signed INT8 result
//   sat   : clamping changed the value (not set for the relu lower bound)
// Rounding is round-half-up toward +inf: (value + 2^(shift-1)) >>> shift, or value when shift=0.
module requant_round_sat
  import npu_pkg::*;
#(
  parameter int unsigned VALUE_W = VAL_W,
  parameter int unsigned SHIFT_W = SHIFT_W_DEF
) (
  input  logic signed [VALUE_W-1:0] value,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic signed [7:0]         zp,
  input  logic                      relu,
  output logic signed [7:0]         data,
  output logic                      sat
);

  // One extra bit absorbs the rounding increment, one more the zero-point add.
  localparam int unsigned R_W = VALUE_W + 1;
  localparam int unsigned V_W = VALUE_W + 2;

  logic signed [R_W-1:0] half;
  logic signed [R_W-1:0] rounded;
  logic signed [V_W-1:0] v;
  logic signed [V_W-1:0] lo;
  logic signed [V_W-1:0] hi;

  always_comb begin
    half = '0;
    if (shift != '0) begin
      half = R_W'(1) << (shift - 1'b1);
    end
    // half is zero when shift is zero, so one expression covers both cases.
    rounded = (R_W'(value) + half) >>> shift;
    v       = V_W'(rounded) + V_W'(zp);
    hi      = V_W'(INT8_MAX);
    lo      = relu ? V_W'(zp) : V_W'(INT8_MIN);

    data = v[7:0];
    sat  = 1'b0;
    if (v > hi) begin
      data = INT8_MAX;
      sat  = 1'b1;
    end else if (v < lo) begin
      data = lo[7:0];
      sat  = !relu;
    end
  end

endmodule

// File: rtl/requant_int8.sv
// requant_int8: three-stage INT32 accumulator -> INT8 requantizer with valid/ready.
//   S1: sum  = acc_in + cfg_bias            (cfg_* captured with the beat)
//   S2: prod = sum * cfg_mult
//   S3: round/shift, add zero point, clamp  (requant_round_sat), registered to out_data
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake; in_ready = !out_valid || out_ready
//   acc_in, cfg_bias      : signed ACC_W accumulator and bias
//   cfg_mult, cfg_shift   : signed scale multiplier, arithmetic right shift (0..47)
//   cfg_zp                : signed output zero point
//   relu_en               : per-beat ReLU lower bound (present only with REQUANT_RELU_EN)
//   out_valid / out_ready : output handshake
//   out_data              : signed INT8 result
//   sat_cnt, cnt_clear    : saturating count of saturated output transfers, sync clear
// Configuration: define REQUANT_RELU_EN to add relu_en; otherwise lower bound is always -128.
// ACC_W + MULT_W + 1 must not exceed npu_pkg::VAL_W, and SHIFT_W must not exceed SHIFT_W_DEF.
module requant_int8
  import npu_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned MULT_W  = MULT_W_DEF,
  parameter int unsigned SHIFT_W = SHIFT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ACC_W-1:0]   acc_in,
  input  logic signed [ACC_W-1:0]   cfg_bias,
  input  logic signed [MULT_W-1:0]  cfg_mult,
  input  logic        [SHIFT_W-1:0] cfg_shift,
  input  logic signed [7:0]         cfg_zp,
`ifdef REQUANT_RELU_EN
  input  logic                      relu_en,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [7:0]         out_data,
  output logic [15:0]               sat_cnt,
  input  logic                      cnt_clear
);

  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned PROD_W = ACC_W + MULT_W + 1;

  logic en;
  logic in_relu;

  logic                      s1_valid;
  logic signed [SUM_W-1:0]   s1_sum;
  logic signed [MULT_W-1:0]  s1_mult;
  logic        [SHIFT_W-1:0] s1_shift;
  logic signed [7:0]         s1_zp;
  logic                      s1_relu;

  logic signed [PROD_W-1:0]  prod;

  logic                      s2_valid;
  beat_t                     s2_beat;

  logic signed [7:0]         rs_data;
  logic                      rs_sat;
  logic                      out_sat;

  // The whole pipeline moves together; it only stalls when a result is stuck at the output.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

`ifdef REQUANT_RELU_EN
  assign in_relu = relu_en;
`else
  assign in_relu = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_mult  <= '0;
      s1_shift <= '0;
      s1_zp    <= '0;
      s1_relu  <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum   <= SUM_W'(acc_in) + SUM_W'(cfg_bias);
        s1_mult  <= cfg_mult;
        s1_shift <= cfg_shift;
        s1_zp    <= cfg_zp;
        s1_relu  <= in_relu;
      end
    end
  end

  assign prod = PROD_W'(s1_sum) * PROD_W'(s1_mult);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_beat  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_beat.value <= VAL_W'(prod);
        s2_beat.shift <= SHIFT_W_DEF'(s1_shift);
        s2_beat.zp    <= s1_zp;
        s2_beat.relu  <= s1_relu;
      end
    end
  end

  requant_round_sat #(
    .VALUE_W (VAL_W),
    .SHIFT_W (SHIFT_W_DEF)
  ) u_round_sat (
    .value (s2_beat.value),
    .shift (s2_beat.shift),
    .zp    (s2_beat.zp),
    .relu  (s2_beat.relu),
    .data  (rs_data),
    .sat   (rs_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= rs_data;
        out_sat  <= rs_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cnt_clear) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: doc/requant_int8.md
REQUANT_INT8 -- requirements
Module: requant_int8

Interface
REQ-001 Parameter ACC_W, 32, accumulator input width, matching the MAC accumulator.
REQ-002 Parameter MULT_W, 16, width of the signed fixed-point scale multiplier.
REQ-003 Parameter SHIFT_W, 6, width of the right-shift amount.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  accumulator beat valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 acc_in  input  ACC_W  signed accumulator value.
REQ-009 cfg_bias  input  ACC_W  signed bias added to acc_in.
REQ-010 cfg_mult  input  MULT_W  signed scale multiplier.
REQ-011 cfg_shift  input  SHIFT_W  arithmetic right shift, 0..47.
REQ-012 cfg_zp  input  8  signed output zero point.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_data  output  8  signed INT8 result.
REQ-016 sat_cnt  output  16  count of saturated results.
REQ-017 cnt_clear  input  1  synchronous clear of sat_cnt.

Function
REQ-018 Three-stage pipeline: S1 sum = acc_in + cfg_bias (ACC_W+1 bits, no overflow); S2 prod = sum * cfg_mult (ACC_W+MULT_W+1 bits); S3 round, shift, add zero point, clamp.
REQ-019 cfg_* sampled together with acc_in at the S1 handshake and carried with the beat; changing cfg mid-stream affects only later beats.
REQ-020 S3 rounding: shift=0 -> r = prod; shift>0 -> r = (prod + 2^(shift-1)) >>> shift (round-half-up toward +inf).
REQ-021 S3 output: v = r + cfg_zp; clamp to [-128,127]; saturation flag set when clamping changed the value.
REQ-022 Latency: a beat accepted in cycle N appears on out_data/out_valid in cycle N+3 when no stall occurs.
REQ-023 Pipeline advance enable en = !out_valid || out_ready; in_ready = en; all stages hold when en=0.
REQ-024 Transfers occur only on in_valid&&in_ready (input) and out_valid&&out_ready (output); out_data stable while out_valid&&!out_ready.
REQ-025 Bubbles propagate as invalid stages; full throughput of one beat per cycle with out_ready held high.
REQ-026 sat_cnt increments by 1 on each output transfer whose saturation flag is set; holds at 0xFFFF.
REQ-027 cnt_clear has priority over an increment in the same cycle; sat_cnt becomes 0.

Reset
REQ-028 rst_n low clears all stage valid bits, out_valid=0, out_data=0, sat_cnt=0, immediately and asynchronously.
REQ-029 Reset mid-operation discards all in-flight beats; in_ready=1 in the first cycle after release.

Configuration
REQ-030 Macro REQUANT_RELU_EN defined: adds input port relu_en (1 bit, sampled per beat like cfg_*); when set, lower clamp bound becomes cfg_zp instead of -128; clamping at this bound does not count as saturation.
REQ-031 REQUANT_RELU_EN undefined: relu_en port absent; lower bound always -128.

Structure
REQ-032 Shared package npu_pkg holds INT8_MIN/INT8_MAX constants, ACC_W default and the per-beat pipeline record type (value, shift, zp, relu).
REQ-033 One sub-module requant_round_sat (combinational S3 round/shift/zp/clamp) is natural; pipeline registers and handshake stay in requant_int8.

Verification
REQ-034 acc=1000, bias=24, mult=1, shift=4, zp=0, out_ready=1 -> out_data=64 three cycles later, sat_cnt=0.
REQ-035 acc=-200, bias=0, mult=3, shift=1, zp=5 -> r=-300 -> clamp -128, sat_cnt=1; then acc=40, mult=1, shift=0, zp=100 -> 127, sat_cnt=2.
REQ-036 Stream 8 beats, out_ready low for cycles 4-6 -> in_ready low same cycles, out_data held, all 8 results in order, none lost or duplicated.
REQ-037 Rounding: prod=7, shift=1 -> 4; prod=-7, shift=1 -> -3; prod=5, shift=0 -> 5.
REQ-038 cnt_clear asserted in cycle of a saturated output transfer -> sat_cnt=0; rst_n pulsed with 2 beats in flight -> out_valid=0 and no stale beat emitted after release.
REQ-039 With REQUANT_RELU_EN, relu_en=1, zp=-10, r=-50 -> out_data=-10, sat_cnt unchanged.
